// File: rtl/voter_tally.sv
// Clocked voting session over N_VOTERS channels: accepts one vote per voter,
// closes on all-voted, explicit close or timeout, then publishes tallies and verdict.
module voter_tally #(
    parameter int unsigned N_VOTERS = 4,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned MAJ_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               close,
    input  logic [N_VOTERS-1:0]                vote_en,
    input  logic [N_VOTERS-1:0]                vote_val,
    output logic [$clog2(N_VOTERS+1)-1:0]      yes_cnt,
    output logic [$clog2(N_VOTERS+1)-1:0]      no_cnt,
    output logic [N_VOTERS-1:0]                voted,
    output logic                               busy,
    output logic                               result_valid,
    output logic                               pass,
    output logic                               tie,
    output logic                               timeout
);

    localparam int unsigned CW = $clog2(N_VOTERS + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OPEN  = 2'd1,
        S_TALLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_yes;
    logic [CW-1:0]         r_no;
    logic [N_VOTERS-1:0]   r_voted;
    logic [TW-1:0]         r_timer;
    logic                  r_busy;
    logic                  r_result_valid;
    logic                  r_pass;
    logic                  r_tie;
    logic                  r_timeout;

    logic [N_VOTERS-1:0]   w_accept;
    logic [N_VOTERS-1:0]   w_acc_yes;
    logic [N_VOTERS-1:0]   w_acc_no;
    logic [N_VOTERS-1:0]   w_voted_next;
    logic [CW-1:0]         w_yes_add;
    logic [CW-1:0]         w_no_add;
    logic                  w_all_voted;
    logic                  w_timer_hit;
    logic                  w_close_evt;
    logic [CW:0]           w_yes_x2;
    logic                  w_pass;
    logic                  w_tie;

    // Vote acceptance: only first vote per voter counts; popcount of this cycle's accepts.
    always_comb begin
        w_accept     = vote_en & ~r_voted;
        w_acc_yes    = w_accept & vote_val;
        w_acc_no     = w_accept & ~vote_val;
        w_voted_next = r_voted | w_accept;
        w_yes_add    = '0;
        w_no_add     = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            w_yes_add = w_yes_add + CW'(w_acc_yes[i]);
            w_no_add  = w_no_add  + CW'(w_acc_no[i]);
        end
        w_all_voted = &w_voted_next;
        w_timer_hit = (r_timer == TW'(TIMEOUT - 1));
        w_close_evt = w_all_voted | close | w_timer_hit;
    end

    // Verdict evaluated at CW+1 bits so doubling the yes count cannot overflow.
    always_comb begin
        w_yes_x2 = {r_yes, 1'b0};
        w_pass   = 1'b0;
        w_tie    = 1'b0;
        if (MAJ_MODE == 0) begin
            w_pass = ({1'b0, r_yes} > {1'b0, r_no});
            w_tie  = (r_yes == r_no);
        end else begin
            w_pass = (w_yes_x2 > (CW+1)'(N_VOTERS));
            w_tie  = (w_yes_x2 == (CW+1)'(N_VOTERS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_yes          <= '0;
            r_no           <= '0;
            r_voted        <= '0;
            r_timer        <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_pass         <= 1'b0;
            r_tie          <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_result_valid <= 1'b0;
                    if (start) begin
                        r_state   <= S_OPEN;
                        r_yes     <= '0;
                        r_no      <= '0;
                        r_voted   <= '0;
                        r_timer   <= '0;
                        r_pass    <= 1'b0;
                        r_tie     <= 1'b0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_OPEN: begin
                    r_voted <= w_voted_next;
                    r_yes   <= r_yes + w_yes_add;
                    r_no    <= r_no + w_no_add;
                    r_timer <= r_timer + TW'(1);
                    if (w_close_evt) begin
                        r_state   <= S_TALLY;
                        r_timeout <= w_timer_hit & ~w_all_voted & ~close;
                    end
                end
                S_TALLY: begin
                    r_state        <= S_DONE;
                    r_pass         <= w_pass;
                    r_tie          <= w_tie;
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign yes_cnt      = r_yes;
    assign no_cnt       = r_no;
    assign voted        = r_voted;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign pass         = r_pass;
    assign tie          = r_tie;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_voter_tally.sv
// Directed bench for voter_tally: one simple-majority and one absolute-majority
// instance share the same stimulus.
module tb_voter_tally;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       close;
    logic [3:0] vote_en;
    logic [3:0] vote_val;

    logic [2:0] yes_a, no_a, yes_b, no_b;
    logic [3:0] voted_a, voted_b;
    logic       busy_a, rv_a, pass_a, tie_a, to_a;
    logic       busy_b, rv_b, pass_b, tie_b, to_b;

    int checks = 0;
    int errors = 0;

    voter_tally #(.N_VOTERS(4), .TIMEOUT(16), .MAJ_MODE(0)) u_simple (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .vote_en(vote_en), .vote_val(vote_val),
        .yes_cnt(yes_a), .no_cnt(no_a), .voted(voted_a), .busy(busy_a),
        .result_valid(rv_a), .pass(pass_a), .tie(tie_a), .timeout(to_a)
    );

    voter_tally #(.N_VOTERS(4), .TIMEOUT(16), .MAJ_MODE(1)) u_abs (
        .clk(clk), .rst_n(rst_n), .start(start), .close(close),
        .vote_en(vote_en), .vote_val(vote_val),
        .yes_cnt(yes_b), .no_cnt(no_b), .voted(voted_b), .busy(busy_b),
        .result_valid(rv_b), .pass(pass_b), .tie(tie_b), .timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; close = 1'b0; vote_en = '0; vote_val = '0;
        tick(); tick();
        chk("rst_yes",   32'(yes_a),   0);
        chk("rst_no",    32'(no_a),    0);
        chk("rst_voted", 32'(voted_a), 0);
        chk("rst_busy",  32'(busy_a),  0);
        chk("rst_rv",    32'(rv_a),    0);
        chk("rst_flags", 32'({pass_a, tie_a, to_a}), 0);
        rst_n = 1'b1;
        tick();

        // all four vote at once: yes=3 no=1, closes on that edge
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_open", 32'(busy_a), 1);
        vote_en = 4'b1111; vote_val = 4'b0111; tick(); vote_en = '0; vote_val = '0;
        chk("t1_voted", 32'(voted_a), 4'hf);
        chk("t1_yes",   32'(yes_a),   3);
        chk("t1_no",    32'(no_a),    1);
        chk("t1_rv_tally", 32'(rv_a), 0);
        chk("t1_busy_tally", 32'(busy_a), 1);
        tick();
        chk("t1_rv",      32'(rv_a),   1);
        chk("t1_pass",    32'(pass_a), 1);
        chk("t1_tie",     32'(tie_a),  0);
        chk("t1_timeout", 32'(to_a),   0);
        chk("t1_busy_done", 32'(busy_a), 0);
        chk("t1_pass_abs", 32'(pass_b), 1);
        tick();
        chk("t1_rv_pulse", 32'(rv_a), 0);
        chk("t1_pass_hold", 32'(pass_a), 1);

        // votes in DONE are ignored
        vote_en = 4'b1111; vote_val = 4'b0000; tick(); vote_en = '0;
        chk("t6_done_yes", 32'(yes_a), 3);
        chk("t6_done_no",  32'(no_a),  1);

        // start in DONE clears everything; then duplicate vote and start-in-OPEN
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_clr_cnt",  32'({yes_a, no_a}), 0);
        chk("t6_clr_voted", 32'(voted_a), 0);
        chk("t6_clr_flags", 32'({pass_a, tie_a, to_a}), 0);
        chk("t6_clr_busy", 32'(busy_a), 1);
        vote_en = 4'b0001; vote_val = 4'b0001; tick();
        chk("t2_first_yes", 32'(yes_a), 1);
        vote_en = 4'b0001; vote_val = 4'b0000; start = 1'b1; tick();
        vote_en = '0; start = 1'b0;
        chk("t2_dup_yes",   32'(yes_a),   1);
        chk("t2_dup_no",    32'(no_a),    0);
        chk("t2_voted",     32'(voted_a), 1);
        chk("t6_start_open_busy", 32'(busy_a), 1);
        close = 1'b1; tick(); close = 1'b0; tick();
        chk("t2_rv",      32'(rv_a),   1);
        chk("t2_pass",    32'(pass_a), 1);
        chk("t2_timeout", 32'(to_a),   0);
        chk("t2_abs_verdict", 32'({pass_b, tie_b}), 0);

        // timeout: OPEN lasts exactly 16 cycles
        start = 1'b1; tick(); start = 1'b0;
        vote_en = 4'b0011; vote_val = 4'b0001; tick(); vote_en = '0; vote_val = '0;
        for (int i = 0; i < 14; i++) tick();
        chk("t3_still_open_rv", 32'(rv_a), 0);
        tick();
        chk("t3_tally_busy", 32'(busy_a), 1);
        chk("t3_tally_rv",   32'(rv_a),   0);
        tick();
        chk("t3_rv",      32'(rv_a),   1);
        chk("t3_timeout", 32'(to_a),   1);
        chk("t3_tie",     32'(tie_a),  1);
        chk("t3_pass",    32'(pass_a), 0);
        chk("t3_abs_verdict", 32'({pass_b, tie_b}), 0);

        // zero votes then close
        start = 1'b1; tick(); start = 1'b0;
        close = 1'b1; tick(); close = 1'b0; tick();
        chk("t3z_rv",      32'(rv_a), 1);
        chk("t3z_verdict", 32'({pass_a, tie_a, to_a}), 3'b010);
        chk("t3z_abs",     32'({pass_b, tie_b, to_b}), 3'b000);

        // 2 yes of 4: simple pass, absolute tie
        start = 1'b1; tick(); start = 1'b0;
        vote_en = 4'b0011; vote_val = 4'b0011; tick(); vote_en = '0; vote_val = '0;
        close = 1'b1; tick(); close = 1'b0; tick();
        chk("t4_simple_2y", 32'({pass_a, tie_a}), 2'b10);
        chk("t4_abs_2y",    32'({pass_b, tie_b}), 2'b01);

        // 3 yes with close on the same edge: votes still counted
        start = 1'b1; tick(); start = 1'b0;
        vote_en = 4'b0111; vote_val = 4'b0111; close = 1'b1; tick();
        vote_en = '0; vote_val = '0; close = 1'b0;
        chk("t4_yes_on_close", 32'(yes_b), 3);
        tick();
        chk("t4_abs_3y",    32'({pass_b, tie_b, to_b}), 3'b100);
        chk("t4_rv_abs",    32'(rv_b), 1);

        // asynchronous reset mid-OPEN
        start = 1'b1; tick(); start = 1'b0;
        vote_en = 4'b0011; vote_val = 4'b0001; tick(); vote_en = '0; vote_val = '0;
        chk("t5_pre_cnt", 32'({yes_a, no_a}), 6'b001001);
        #2 rst_n = 1'b0; #1;
        chk("t5_async_cnt",   32'({yes_a, no_a}), 0);
        chk("t5_async_voted", 32'(voted_a), 0);
        chk("t5_async_busy",  32'(busy_a), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t5_no_rv", 32'(rv_a), 0);
        start = 1'b1; tick(); start = 1'b0;
        vote_en = 4'b1111; vote_val = 4'b1100; tick(); vote_en = '0; vote_val = '0;
        tick();
        chk("t5_fresh_rv",  32'(rv_a), 1);
        chk("t5_fresh_cnt", 32'({yes_a, no_a}), 6'b010010);
        chk("t5_fresh_simple", 32'({pass_a, tie_a}), 2'b01);
        chk("t5_fresh_abs",    32'({pass_b, tie_b}), 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
